// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared core constants for the register file, decoder and result mux
package reg_file_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int REG_AW = $clog2(NREGS);
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: write-back, read-port and debug signals between the core and the register file
interface reg_file_if #(
  parameter int XLEN = reg_file_pkg::XLEN,
  parameter int NREGS = reg_file_pkg::NREGS,
  parameter int WCNT_W = 32
);
  localparam int AW = $clog2(NREGS);
  logic WE3;
  logic [AW-1:0] A3;
  logic [XLEN-1:0] WD3;
  logic [AW-1:0] A1;
  logic [AW-1:0] A2;
  logic [AW-1:0] ADbg;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic [XLEN-1:0] RDDbg;
  logic [WCNT_W-1:0] WriteCount;
  modport master (
    output WE3, A3, WD3, A1, A2, ADbg,
    input RD1, RD2, RDDbg, WriteCount
  );
  modport slave (
    input WE3, A3, WD3, A1, A2, ADbg,
    output RD1, RD2, RDDbg, WriteCount
  );
endinterface

// File: rtl/reg_read_port.sv
// reg_read_port: combinational register read with x0 forcing; REG_FILE_BYPASS_EN adds write-data forwarding
module reg_read_port #(
  parameter int XLEN = reg_file_pkg::XLEN,
  parameter int NREGS = reg_file_pkg::NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input logic reset,
  input logic [XLEN-1:0] regs [NREGS],
`ifdef REG_FILE_BYPASS_EN
  input logic we,
  input logic [AW-1:0] wa,
  input logic [XLEN-1:0] wd,
`endif
  input logic [AW-1:0] addr,
  output logic [XLEN-1:0] rd
);
  import reg_file_pkg::*;
  logic zero;
  assign zero = reset || addr == AW'(ZERO_REG);
`ifdef REG_FILE_BYPASS_EN
  assign rd = zero ? '0 : (we && wa == addr) ? wd : regs[addr];
`else
  assign rd = zero ? '0 : regs[addr];
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: NREGS x XLEN register file, two read ports plus debug port, commit counter; optional REG_FILE_BYPASS_EN
module reg_file #(
  parameter int XLEN = reg_file_pkg::XLEN,
  parameter int NREGS = reg_file_pkg::NREGS,
  parameter int WCNT_W = 32
) (
  input logic clk,
  input logic reset,
  reg_file_if.slave bus
);
  import reg_file_pkg::*;
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] regs [NREGS];
  logic [WCNT_W-1:0] wcnt;
  logic commit;
  assign commit = bus.WE3 && bus.A3 != AW'(ZERO_REG);
  assign bus.WriteCount = wcnt;
  // register storage and commit counter; x0 is never written so it stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wcnt <= '0;
    end else if (commit) begin
      regs[bus.A3] <= bus.WD3;
      wcnt <= wcnt + WCNT_W'(1);
    end
  end
  reg_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rd1 (
    .reset(reset),
    .regs(regs),
`ifdef REG_FILE_BYPASS_EN
    .we(bus.WE3),
    .wa(bus.A3),
    .wd(bus.WD3),
`endif
    .addr(bus.A1),
    .rd(bus.RD1)
  );
  reg_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rd2 (
    .reset(reset),
    .regs(regs),
`ifdef REG_FILE_BYPASS_EN
    .we(bus.WE3),
    .wa(bus.A3),
    .wd(bus.WD3),
`endif
    .addr(bus.A2),
    .rd(bus.RD2)
  );
  reg_read_port #(.XLEN(XLEN), .NREGS(NREGS)) u_rdd (
    .reset(reset),
    .regs(regs),
`ifdef REG_FILE_BYPASS_EN
    .we(bus.WE3),
    .wa(bus.A3),
    .wd(bus.WD3),
`endif
    .addr(bus.ADbg),
    .rd(bus.RDDbg)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven scoreboard bench for reg_file, with a 4-bit counter instance for wrap checks
module tb_reg_file;
  import reg_file_pkg::*;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  reg_file_if #(.XLEN(32), .NREGS(32), .WCNT_W(32)) bus ();
  reg_file_if #(.XLEN(32), .NREGS(32), .WCNT_W(4)) bus4 ();
  reg_file #(.XLEN(32), .NREGS(32), .WCNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  reg_file #(.XLEN(32), .NREGS(32), .WCNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  assign bus4.WE3 = bus.WE3;
  assign bus4.A3 = bus.A3;
  assign bus4.WD3 = bus.WD3;
  assign bus4.A1 = bus.A1;
  assign bus4.A2 = bus.A2;
  assign bus4.ADbg = bus.ADbg;

  typedef struct {
    logic we;
    logic [4:0] a3;
    logic [31:0] wd;
    logic [4:0] a1, a2, ad;
    logic [31:0] e1, e2, ed, ecnt;
  } vec_t;
  typedef struct {
    logic [31:0] e1, e2, ed, ecnt;
    string tag;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".rd1"}, bus.RD1, e.e1);
      cmp({e.tag, ".rd2"}, bus.RD2, e.e2);
      cmp({e.tag, ".rddbg"}, bus.RDDbg, e.ed);
      cmp({e.tag, ".wcnt"}, bus.WriteCount, e.ecnt);
      cmp({e.tag, ".wcnt4"}, {28'd0, bus4.WriteCount}, {28'd0, e.ecnt[3:0]});
    end
  endtask

  task automatic expect_now(input logic [31:0] e1, e2, ed, ecnt, input string tag);
    sb.push_back('{e1, e2, ed, ecnt, tag});
    #1;
    check();
  endtask

  task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                       input logic [4:0] a1, a2, ad,
                       input logic [31:0] e1, e2, ed, ecnt, input string tag);
    @(negedge clk);
    bus.WE3 = we;
    bus.A3 = a3;
    bus.WD3 = wd;
    bus.A1 = a1;
    bus.A2 = a2;
    bus.ADbg = ad;
    sb.push_back('{e1, e2, ed, ecnt, tag});
    #2;
    check();
  endtask

  task automatic write_only(input logic [4:0] a3, input logic [31:0] wd);
    @(negedge clk);
    bus.WE3 = 1'b1;
    bus.A3 = a3;
    bus.WD3 = wd;
    bus.A1 = '0;
    bus.A2 = '0;
    bus.ADbg = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  5'd0,  32'h0,        32'h0,        32'h0,        32'd0};
    tbl[1] = '{1'b0, 5'd6,  32'h11111111, 5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd6,  32'h0,        32'h0,        32'h0,        32'd1};
    tbl[3] = '{1'b1, 5'd9,  32'hCAFEF00D, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'd1};
    tbl[4] = '{1'b1, 5'd10, 32'h0BADC0DE, 5'd9,  5'd5,  5'd6,  32'hCAFEF00D, 32'hDEADBEEF, 32'h0,        32'd2};
    tbl[5] = '{1'b1, 5'd31, 32'h80000001, 5'd10, 5'd9,  5'd0,  32'h0BADC0DE, 32'hCAFEF00D, 32'h0,        32'd3};
    tbl[6] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd10, 5'd31, 32'h80000001, 32'h0BADC0DE, 32'h80000001, 32'd4};
    tbl[7] = '{1'b1, 5'd5,  32'h0,        5'd31, 5'd0,  5'd9,  32'h80000001, 32'h0,        32'hCAFEF00D, 32'd4};
    tbl[8] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd5,  5'd10, 32'h0,        32'h0,        32'h0BADC0DE, 32'd5};
    bus.WE3 = 1'b0;
    bus.A3 = '0;
    bus.WD3 = '0;
    bus.A1 = 5'd3;
    bus.A2 = 5'd17;
    bus.ADbg = 5'd31;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_now(32'h0, 32'h0, 32'h0, 32'd0, "reset_state");
    for (int i = 0; i < 9; i++)
      drive(tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].a1, tbl[i].a2, tbl[i].ad,
            tbl[i].e1, tbl[i].e2, tbl[i].ed, tbl[i].ecnt, $sformatf("vec%0d", i));
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd0,
          BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 32'h0, 32'd5, "same_cycle");
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7,
          32'h12345678, 32'h12345678, 32'h12345678, 32'd6, "after_write7");
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'd6, "write3");
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3,
          32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd7, "read3");
    #1 reset = 1'b1;
    expect_now(32'h0, 32'h0, 32'h0, 32'd0, "async_reset");
    drive(1'b1, 5'd4, 32'h77, 5'd4, 5'd4, 5'd4, 32'h0, 32'h0, 32'h0, 32'd0, "rst_hold_a");
    drive(1'b1, 5'd4, 32'h77, 5'd4, 5'd4, 5'd4, 32'h0, 32'h0, 32'h0, 32'd0, "rst_hold_b");
    reset = 1'b0;
    expect_now(BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, 32'd0, "rst_release");
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 5'd4, 32'h77, 32'h77, 32'h77, 32'd1, "first_write");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i < 32; i++) write_only(5'(i), 32'(i));
    for (int i = 0; i < 32; i++)
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i), 32'(i), 32'(i), 32'(i), 32'd31,
            $sformatf("sweep%0d", i));
    drive(1'b1, 5'd1, 32'hFFFF0000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'd31, "wrap_write");
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd0, 32'hFFFF0000, 32'd2, 32'h0, 32'd32, "wrap_check");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter XLEN, default 32: data width of every register and data port.
REQ-002 Parameter NREGS, default 32: register count; address width is clog2(NREGS), 5 at default.
REQ-003 Parameter WCNT_W, default 32: width of the committed-write counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 WE3  input  1  write-back enable from the control unit (RegWrite).
REQ-007 A3  input  5  write-back destination register (rd).
REQ-008 WD3  input  XLEN  write-back data from the result mux.
REQ-009 A1  input  5  read port 1 address (rs1).
REQ-010 A2  input  5  read port 2 address (rs2).
REQ-011 RD1  output  XLEN  read port 1 data, combinational.
REQ-012 RD2  output  XLEN  read port 2 data, combinational.
REQ-013 ADbg  input  5  debug read address.
REQ-014 RDDbg  output  XLEN  debug read data, combinational.
REQ-015 WriteCount  output  WCNT_W  count of committed non-x0 writes since reset.

Function
REQ-016 Write: on a rising clk edge with WE3=1 and A3!=0, register[A3] SHALL take WD3 and be visible on the read ports from the next cycle.
REQ-017 A write with A3=0 SHALL be discarded; x0 reads 0 on every port at all times.
REQ-018 WE3=0 SHALL leave every register unchanged regardless of A3/WD3.
REQ-019 RD1/RD2/RDDbg SHALL be pure combinational functions of their addresses and current register contents, with zero-cycle latency.
REQ-020 Identical addresses on A1, A2 and ADbg SHALL return identical data.
REQ-021 WriteCount SHALL increment by 1 on each edge where a write commits (REQ-016); it SHALL wrap from all-ones to 0 with no saturation.
REQ-022 Writes to A3=0 and edges with WE3=0 SHALL NOT increment WriteCount.
REQ-023 Same-cycle read of A3 while WE3=1 (bypass off) SHALL return the old register value.

Reset
REQ-024 Asserting reset SHALL immediately clear all registers and WriteCount to 0, independent of clk.
REQ-025 While reset is high, writes SHALL be ignored and RD1/RD2/RDDbg SHALL read 0.
REQ-026 A write coinciding with the deasserting reset edge SHALL be dropped; the first write accepted is on the first rising clk edge with reset low.
REQ-027 Reset asserted between two writes SHALL lose the earlier write; no partial state survives.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN: when defined, a read port whose address equals A3 while WE3=1 and A3!=0 SHALL return WD3 combinationally, which gives write-before-read behaviour.
REQ-029 When REG_FILE_BYPASS_EN is undefined, REQ-023 applies; no other behaviour differs between builds.
REQ-030 The bypass SHALL never apply to x0 or while reset is high.

Structure
REQ-031 XLEN, NREGS, register-address width and the register-index constant ZERO_REG (0) SHALL live in the shared core package used by the decoder and result mux.
REQ-032 Read-port logic (address -> data with x0 forcing and optional bypass) SHALL be one sub-module, reg_read_port, instantiated three times.
REQ-033 Storage and WriteCount SHALL reside in reg_file itself; no memory macros.

Verification
REQ-034 Reset, then WE3=1 A3=5 WD3=0xDEADBEEF; next cycle A1=5 -> RD1=0xDEADBEEF, WriteCount=1.
REQ-035 WE3=1 A3=0 WD3=0xFFFFFFFF; A1=A2=ADbg=0 -> all read 0, WriteCount unchanged.
REQ-036 Same cycle WE3=1 A3=7 WD3=0x12345678, A1=7 (reg7=0x0) -> RD1=0x0 without bypass, 0x12345678 with REG_FILE_BYPASS_EN; next cycle both 0x12345678.
REQ-037 Write all regs 1..31 with value = index, then sweep A1/A2/ADbg -> each returns its index, x0=0, WriteCount=31.
REQ-038 Assert reset mid-cycle between clk edges after writing reg3=0xA5A5A5A5 -> RD on A1=3 drops to 0 before the next edge, WriteCount=0.
REQ-039 Force WriteCount near wrap (WCNT_W=4 build, 16 commits) -> reads 0 after the 16th write.
